// File: rtl/dsp_pkg.sv
// Shared DSP helpers: width derivations used by the mixer/decimator and
// later CIC stages.
package dsp_pkg;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

    // Accumulator width that cannot overflow when summing dec products of
    // two signed operands of widths in_a and in_b.
    function automatic int unsigned acc_width_for(input int unsigned in_a,
                                                  input int unsigned in_b,
                                                  input int unsigned dec);
        return in_a + in_b + clog2(dec);
    endfunction

    // LSBs dropped when keeping the top out_w bits of an acc_w-bit value.
    function automatic int unsigned trunc_lsbs(input int unsigned acc_w,
                                               input int unsigned out_w);
        return acc_w - out_w;
    endfunction

endpackage

// File: rtl/integrate_dump.sv
// Integrate-and-dump for one channel: sums signed products and emits the
// top OUT_WIDTH bits of the block sum when dump is asserted.
module integrate_dump
    import dsp_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 15,
    parameter int unsigned ACC_WIDTH  = 17,
    parameter int unsigned OUT_WIDTH  = 17,
    parameter int unsigned DECIMATION = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 en,
    input  logic                 dump,
    input  logic [IN_WIDTH-1:0]  prod,
    output logic [OUT_WIDTH-1:0] result
);

    localparam int unsigned DROP = trunc_lsbs(ACC_WIDTH, OUT_WIDTH);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;

    // Running sum including the product presented this cycle.
    always_comb begin
        sum = acc + ACC_WIDTH'($signed(prod));
    end

    // Accumulate on enable; on dump publish the truncated block sum and restart.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc    <= '0;
            result <= '0;
        end else if (en) begin
            if (dump) begin
                result <= sum[DROP +: OUT_WIDTH];
                acc    <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/iq_mixer_decimator.sv
// DDC front stage: mixes ADC samples with the NCO sine/cosine into I/Q
// products and integrate-and-dumps DECIMATION products per output.
module iq_mixer_decimator
    import dsp_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 8,
    parameter int unsigned SINE_WIDTH = 7,
    parameter int unsigned DECIMATION = 4,
    parameter int unsigned OUT_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  sample_clk_ce,
    input  logic [ADC_WIDTH-1:0]  adc_sample,
    input  logic [SINE_WIDTH-1:0] sinewave,
    input  logic [SINE_WIDTH-1:0] cosinewave,
    output logic [OUT_WIDTH-1:0]  i_out,
    output logic [OUT_WIDTH-1:0]  q_out,
    output logic                  out_valid
);

    localparam int unsigned PROD_WIDTH = ADC_WIDTH + SINE_WIDTH;
    localparam int unsigned ACC_WIDTH  = acc_width_for(ADC_WIDTH, SINE_WIDTH, DECIMATION);
    localparam int unsigned CNT_WIDTH  = clog2(DECIMATION);

    if (OUT_WIDTH > ACC_WIDTH) begin : g_out_width_check
        $error("OUT_WIDTH must not exceed ACC_WIDTH");
    end
    if (DECIMATION < 2) begin : g_decimation_check
        $error("DECIMATION must be at least 2");
    end

    logic [PROD_WIDTH-1:0] adc_ext;
    logic [PROD_WIDTH-1:0] sin_ext;
    logic [PROD_WIDTH-1:0] cos_ext;
    logic [PROD_WIDTH-1:0] prod_i;
    logic [PROD_WIDTH-1:0] prod_q;
    logic                  p_valid;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  en;
    logic                  dump;

    // Sign-extend operands so the multiply is carried out at full product width.
    always_comb begin
        adc_ext = PROD_WIDTH'($signed(adc_sample));
        sin_ext = PROD_WIDTH'($signed(sinewave));
        cos_ext = PROD_WIDTH'($signed(cosinewave));
    end

    // Mixer stage: register I/Q products on every sample tick.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prod_i  <= '0;
            prod_q  <= '0;
            p_valid <= 1'b0;
        end else if (sample_clk_ce) begin
            prod_i  <= $signed(adc_ext) * $signed(cos_ext);
            prod_q  <= $signed(adc_ext) * $signed(sin_ext);
            p_valid <= 1'b1;
        end
    end

    // Accumulation only starts once stage 1 holds a real product.
    always_comb begin
        en   = sample_clk_ce & p_valid;
        dump = (cnt == CNT_WIDTH'(DECIMATION - 1));
    end

    // Shared block counter and one-clock output strobe for both channels.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (en) begin
                if (dump) begin
                    cnt       <= '0;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    integrate_dump #(
        .IN_WIDTH   (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .DECIMATION (DECIMATION)
    ) u_int_i (
        .clk    (clk),
        .arst   (arst),
        .en     (en),
        .dump   (dump),
        .prod   (prod_i),
        .result (i_out)
    );

    integrate_dump #(
        .IN_WIDTH   (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .DECIMATION (DECIMATION)
    ) u_int_q (
        .clk    (clk),
        .arst   (arst),
        .en     (en),
        .dump   (dump),
        .prod   (prod_q),
        .result (q_out)
    );

endmodule

// File: tb/tb_iq_mixer_decimator.sv
// Scoreboard bench for iq_mixer_decimator: three configurations
// (defaults, OUT_WIDTH=12, DECIMATION=3) driven with directed vectors.
module tb_iq_mixer_decimator;

    typedef struct {
        int i;
        int q;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  ce;
    logic [2:0]  arst;
    logic [7:0]  adc [3];
    logic [6:0]  sn  [3];
    logic [6:0]  cs  [3];
    logic [16:0] i0, q0, i2, q2;
    logic [11:0] i1, q1;
    logic [2:0]  ov;

    int   obs_i [3];
    int   obs_q [3];
    exp_t exp_q [3][$];
    int   ce_cnt [3];
    int   pend_i [3];
    int   pend_q [3];
    int   last_i [3];
    int   last_q [3];
    bit   mon_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    iq_mixer_decimator u_def (
        .clk(clk), .arst(arst[0]), .sample_clk_ce(ce[0]),
        .adc_sample(adc[0]), .sinewave(sn[0]), .cosinewave(cs[0]),
        .i_out(i0), .q_out(q0), .out_valid(ov[0])
    );

    iq_mixer_decimator #(.OUT_WIDTH(12)) u_w12 (
        .clk(clk), .arst(arst[1]), .sample_clk_ce(ce[1]),
        .adc_sample(adc[1]), .sinewave(sn[1]), .cosinewave(cs[1]),
        .i_out(i1), .q_out(q1), .out_valid(ov[1])
    );

    iq_mixer_decimator #(.DECIMATION(3)) u_d3 (
        .clk(clk), .arst(arst[2]), .sample_clk_ce(ce[2]),
        .adc_sample(adc[2]), .sinewave(sn[2]), .cosinewave(cs[2]),
        .i_out(i2), .q_out(q2), .out_valid(ov[2])
    );

    always_comb begin
        obs_i[0] = int'($signed(i0));
        obs_q[0] = int'($signed(q0));
        obs_i[1] = int'($signed(i1));
        obs_q[1] = int'($signed(q1));
        obs_i[2] = int'($signed(i2));
        obs_q[2] = int'($signed(q2));
    end

    function automatic int dec_of(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor per DUT: pop on out_valid, otherwise outputs must hold.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        exp_t e;
        always @(negedge clk) begin
            if (mon_en) begin
                if (ov[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("dut%0d unexpected out_valid", g), int'(ov[g]), 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("dut%0d valid cycle", g), cyc, e.cyc);
                        check($sformatf("dut%0d i_out", g), obs_i[g], e.i);
                        check($sformatf("dut%0d q_out", g), obs_q[g], e.q);
                        last_i[g] = e.i;
                        last_q[g] = e.q;
                    end
                end else begin
                    check($sformatf("dut%0d i_out hold", g), obs_i[g], last_i[g]);
                    check($sformatf("dut%0d q_out hold", g), obs_q[g], last_q[g]);
                end
            end
        end
    end

    // n ce ticks with constant inputs, gap idle clks after each; ei/eq is the
    // hand-computed result of every block completed inside this call.
    task automatic run(input int d, input int n, input int gap,
                       input int a, input int c, input int s,
                       input int ei, input int eq);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            adc[d] = 8'(a);
            cs[d]  = 7'(c);
            sn[d]  = 7'(s);
            ce[d]  = 1'b1;
            ce_cnt[d]++;
            if (ce_cnt[d] > 1 && (ce_cnt[d] - 1) % dec_of(d) == 0) begin
                x.i   = pend_i[d];
                x.q   = pend_q[d];
                x.cyc = cyc + 1;
                exp_q[d].push_back(x);
            end
            if (ce_cnt[d] % dec_of(d) == 0) begin
                pend_i[d] = ei;
                pend_q[d] = eq;
            end
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                ce[d]  = 1'b0;
                adc[d] = 8'($urandom);
                cs[d]  = 7'($urandom);
                sn[d]  = 7'($urandom);
            end
        end
        @(negedge clk);
        ce[d] = 1'b0;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        #2;
        arst[d]   = 1'b1;
        last_i[d] = 0;
        last_q[d] = 0;
        ce_cnt[d] = 0;
        #1;
        check($sformatf("dut%0d async reset i_out", d), obs_i[d], 0);
        check($sformatf("dut%0d async reset q_out", d), obs_q[d], 0);
        check($sformatf("dut%0d async reset out_valid", d), int'(ov[d]), 0);
        @(negedge clk);
        arst[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 3'b111;
        ce   = 3'b000;
        for (int d = 0; d < 3; d++) begin
            adc[d] = '0;
            sn[d]  = '0;
            cs[d]  = '0;
            ce_cnt[d] = 0;
            pend_i[d] = 0;
            pend_q[d] = 0;
            last_i[d] = 0;
            last_q[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset i_out", d), obs_i[d], 0);
            check($sformatf("dut%0d reset q_out", d), obs_q[d], 0);
            check($sformatf("dut%0d reset out_valid", d), int'(ov[d]), 0);
        end
        arst   = 3'b000;
        mon_en = 1'b1;

        // Defaults: 100*63*4 = 25200; worst-case corner; ce every 3rd clk.
        run(0, 8, 0, 100, 63, 0, 25200, 0);
        run(0, 4, 0, -128, -64, 63, 32768, -32256);
        run(0, 8, 2, 100, 63, 0, 25200, 0);
        // Two products accumulated then reset: the partial block is lost.
        run(0, 3, 0, 100, 63, 0, 0, 0);
        do_reset(0);
        run(0, 4, 0, 100, 63, 0, 25200, 0);
        run(0, 1, 0, 0, 0, 0, 0, 0);

        // OUT_WIDTH=12: floor(25200/32)=787, floor(-25200/32)=-788.
        run(1, 4, 0, 100, 63, 0, 787, 0);
        run(1, 4, 0, 100, -63, 0, -788, 0);
        run(1, 1, 0, 0, 0, 0, 0, 0);

        // DECIMATION=3: 10*-5*3=-150, 10*7*3=210.
        run(2, 6, 0, 10, -5, 7, -150, 210);
        run(2, 1, 0, 0, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d outstanding expected outputs", d), exp_q[d].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iq_mixer_decimator.md
Name: iq_mixer_decimator

Overview:
Digital down-converter front stage. It consumes the NCO's registered sinewave/cosinewave and an ADC sample stream, all qualified by sample_clk_ce. It mixes the sample to baseband I/Q and integrate-and-dumps DECIMATION products per channel. The result is decimated I/Q with a one-clock out_valid strobe for the downstream CIC/FIR chain.

Parameters:
ADC_WIDTH, 8, signed ADC sample width
SINE_WIDTH, 7, signed LO width; matches NCO output
DECIMATION, 4, products summed per output; legal range >= 2
OUT_WIDTH, 17, output width; must be <= ACC_WIDTH, otherwise elaboration error
ACC_WIDTH (localparam), ADC_WIDTH+SINE_WIDTH+clog2(DECIMATION), accumulator width

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
sample_clk_ce  in  1  sample-rate clock enable, same strobe that drives the NCO
adc_sample  in  ADC_WIDTH  signed ADC sample
sinewave  in  SINE_WIDTH  signed NCO sine
cosinewave  in  SINE_WIDTH  signed NCO cosine
i_out  out  OUT_WIDTH  signed decimated in-phase sum
q_out  out  OUT_WIDTH  signed decimated quadrature sum
out_valid  out  1  one-clk strobe; i_out/q_out are new

Behaviour:
- Reset (arst high, asynchronous): every register clears to 0, including:
  - prod_i, prod_q, p_valid
  - acc_i, acc_q, cnt
  - i_out, q_out, out_valid
- Nothing advances while sample_clk_ce is low. All state holds, except out_valid, which returns to 0 on the next clk.
- Stage 1, mixer, on each ce:
  - prod_i <= adc_sample*cosinewave
  - prod_q <= adc_sample*sinewave
  - Full-precision signed product, ADC_WIDTH+SINE_WIDTH bits.
  - p_valid <= 1 (sticky until reset).
  - All three inputs are sampled at the same edge; no extra alignment delay.
- Stage 2, integrate-and-dump, on ce with p_valid=1:
  - Products are sign-extended to ACC_WIDTH.
  - If cnt < DECIMATION-1: acc <= acc+prod, cnt <= cnt+1.
  - If cnt == DECIMATION-1 (dump):
    - i_out/q_out <= (acc+prod)[ACC_WIDTH-1 -: OUT_WIDTH], i.e. truncation toward -infinity with LSBs dropped.
    - acc <= 0, cnt <= 0, out_valid <= 1 for exactly one clk.
- Startup: the first ce after reset only fills stage 1; its accumulate is skipped because p_valid=0.
- Latency: first out_valid occurs on the clk edge of the (DECIMATION+1)th ce after reset. Each later out_valid comes every DECIMATION ce ticks.
- Overflow: ACC_WIDTH is sized so that DECIMATION worst-case products (-2^(A-1) * -2^(S-1)) never overflow. No saturation logic.
- Back-to-back ce (ce held high): full throughput, one sample per clk; out_valid pulses every DECIMATION clks.
- Reset mid-block: the partial sum is discarded. The next block needs DECIMATION fresh products and repeats the startup latency.
- cnt width is clog2(DECIMATION). Non-power-of-two DECIMATION wraps at DECIMATION-1, not at 2^n-1.
- Sign convention: Q = +x*sin. A spectral flip, if needed, is done downstream.

Decomposition:
- Shared package dsp_pkg holds:
  - the clog2 function
  - the ACC_WIDTH derivation helper
  - the truncate-to-MSBs width rule, reused by later CIC stages
- One natural sub-module, integrate_dump, instantiated twice (I and Q).
  - Parameters: IN_WIDTH, ACC_WIDTH, OUT_WIDTH, DECIMATION.
  - Shared cnt/p_valid live in the top level.
  - integrate_dump takes an en input and a dump input.

Test Plan:
1. Default params; adc_sample=100, cosinewave=63, sinewave=0, ce every clk. Expect:
   - first out_valid on the 5th ce edge after reset release
   - i_out=25200, q_out=0
   - out_valid then every 4 clks, one clk wide
2. adc=-128, cos=-64, sin=63. Expect i_out=32768 (no overflow at 17 bits) and q_out=-32256.
3. OUT_WIDTH=12, adc=100, cos=63, then cos=-63. Expect i_out=787, then i_out=-788 (floor truncation of ±25200>>5).
4. ce asserted every 3rd clk with values as in scenario 1. Expect:
   - identical outputs
   - out_valid every 12 clks, 1 clk wide
   - all state holds between ce pulses
5. arst pulsed after 2 accumulated products with adc=100, cos=63 held. Expect:
   - all outputs 0 immediately, asynchronously
   - next out_valid on the 5th ce after release
   - i_out=25200, with no residue from the aborted block
6. DECIMATION=3 (ACC_WIDTH=17), adc=10, cos=-5, sin=7, ce every clk. Expect:
   - i_out=-150, q_out=210
   - out_valid every 3 clks, cnt wraps 0,1,2
